// File: rtl/mips_core_pkg.sv
// Shared mips_core types and default sizes used by the rename register file
// and its free-list sub-module.
package mips_core_pkg;

  localparam int ARCH_REGS_DEFAULT  = 32;
  localparam int PHYS_REGS_DEFAULT  = 64;
  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef logic [$clog2(ARCH_REGS_DEFAULT)-1:0] arch_tag_t;
  typedef logic [$clog2(PHYS_REGS_DEFAULT)-1:0] phys_tag_t;

endpackage

// File: rtl/free_list_alloc.sv
// Free physical-tag tracker: bit-vector free list with lowest-index allocation,
// registered popcount and a whole-vector rebuild used on flush.
module free_list_alloc
  import mips_core_pkg::*;
#(
  parameter int  ARCH_REGS = ARCH_REGS_DEFAULT,
  parameter int  PHYS_REGS = PHYS_REGS_DEFAULT,
  localparam int PW        = $clog2(PHYS_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_alloc,
  input  logic                 i_release,
  input  logic [PW-1:0]        i_release_tag,
  input  logic                 i_rebuild,
  input  logic [PHYS_REGS-1:0] i_rebuild_vec,
  output logic [PW-1:0]        o_tag,
  output logic                 o_empty,
  output logic [PW:0]          o_count,
  output logic [PHYS_REGS-1:0] o_free_vec
);

  logic [PHYS_REGS-1:0] r_free;
  logic [PHYS_REGS-1:0] w_free_next;
  logic [PW:0]          r_count;
  logic [PW:0]          w_count_next;

  // Scanning downward leaves the lowest set index as the final assignment.
  always_comb begin
    o_tag = '0;
    for (int p = PHYS_REGS - 1; p >= 0; p--) begin
      if (r_free[p]) o_tag = PW'(p);
    end
  end

  assign o_empty = ~|r_free;

  always_comb begin
    w_free_next = r_free;
    if (i_rebuild) begin
      w_free_next = i_rebuild_vec;
    end else begin
      if (i_alloc && !o_empty) w_free_next[o_tag] = 1'b0;
      if (i_release)           w_free_next[i_release_tag] = 1'b1;
    end
  end

  // Counting the next vector keeps free_count in step with the free bits.
  always_comb begin
    w_count_next = '0;
    for (int p = 0; p < PHYS_REGS; p++) begin
      w_count_next = w_count_next + (PW+1)'(w_free_next[p]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PHYS_REGS; p++) begin
        r_free[p] <= (p >= ARCH_REGS);
      end
      r_count <= (PW+1)'(PHYS_REGS - ARCH_REGS);
    end else begin
      r_free  <= w_free_next;
      r_count <= w_count_next;
    end
  end

  assign o_count    = r_count;
  assign o_free_vec = r_free;

endmodule

// File: rtl/rename_reg_file.sv
// Physical register file with speculative/committed rename maps, ready bits and
// flush recovery. Optional same-cycle write-back bypass: RENAME_RF_WB_BYPASS_EN.
module rename_reg_file
  import mips_core_pkg::*;
#(
  parameter int  ARCH_REGS  = ARCH_REGS_DEFAULT,
  parameter int  PHYS_REGS  = PHYS_REGS_DEFAULT,
  parameter int  DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int  NUM_READ   = 2,
  localparam int AW         = $clog2(ARCH_REGS),
  localparam int PW         = $clog2(PHYS_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ren_valid,
  input  logic [AW-1:0]                  ren_arch,
  output logic                           ren_ready,
  output logic [PW-1:0]                  ren_phys,
  output logic [PW-1:0]                  ren_old_phys,
  input  logic [NUM_READ*AW-1:0]         rd_arch,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ*PW-1:0]         rd_phys,
  output logic [NUM_READ-1:0]            rd_rdy,
  input  logic                           wb_valid,
  input  logic [PW-1:0]                  wb_phys,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           cm_valid,
  input  logic [AW-1:0]                  cm_arch,
  input  logic [PW-1:0]                  cm_phys,
  input  logic [PW-1:0]                  cm_old_phys,
  input  logic                           flush,
  output logic [PW:0]                    free_count
);

  logic [PW-1:0]         r_spec_map   [ARCH_REGS];
  logic [PW-1:0]         r_commit_map [ARCH_REGS];
  logic [DATA_WIDTH-1:0] r_regs       [PHYS_REGS];
  logic [PHYS_REGS-1:0]  r_ready;

  logic [PW-1:0]         w_commit_next [ARCH_REGS];
  logic [PHYS_REGS-1:0]  w_in_use;
  logic [PHYS_REGS-1:0]  w_rebuild_vec;
  logic [PHYS_REGS-1:0]  w_free_vec;
  logic [PW-1:0]         w_alloc_tag;
  logic                  w_empty;
  logic                  w_ren_fire;
  logic                  w_cm_fire;
  logic                  w_wb_fire;

  assign w_ren_fire = ren_valid && !w_empty && (ren_arch != '0) && !flush;
  assign w_cm_fire  = cm_valid && (cm_arch != '0);
  assign w_wb_fire  = wb_valid && (wb_phys != '0);

  assign ren_ready    = !w_empty;
  assign ren_phys     = (ren_arch == '0) ? '0 : w_alloc_tag;
  assign ren_old_phys = (ren_arch == '0) ? '0 : r_spec_map[ren_arch];

  // Flush restores from the committed map as it stands after this cycle's
  // commit, and every tag that map does not reference goes back to the pool.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      w_commit_next[i] = r_commit_map[i];
    end
    if (w_cm_fire) w_commit_next[cm_arch] = cm_phys;
    w_in_use = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      w_in_use[w_commit_next[i]] = 1'b1;
    end
  end

  assign w_rebuild_vec = ~w_in_use;

  free_list_alloc #(
    .ARCH_REGS (ARCH_REGS),
    .PHYS_REGS (PHYS_REGS)
  ) u_free_list (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc       (w_ren_fire),
    .i_release     (w_cm_fire),
    .i_release_tag (cm_old_phys),
    .i_rebuild     (flush),
    .i_rebuild_vec (w_rebuild_vec),
    .o_tag         (w_alloc_tag),
    .o_empty       (w_empty),
    .o_count       (free_count),
    .o_free_vec    (w_free_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec_map[i]   <= PW'(i);
        r_commit_map[i] <= PW'(i);
      end
    end else begin
      if (w_cm_fire) r_commit_map[cm_arch] <= cm_phys;
      if (flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          r_spec_map[i] <= w_commit_next[i];
        end
      end else if (w_ren_fire) begin
        r_spec_map[ren_arch] <= w_alloc_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PHYS_REGS; p++) begin
        r_regs[p]  <= '0;
        r_ready[p] <= (p < ARCH_REGS);
      end
    end else begin
      if (w_ren_fire) r_ready[w_alloc_tag] <= 1'b0;
      if (w_wb_fire) begin
        r_regs[wb_phys]  <= wb_data;
        r_ready[wb_phys] <= 1'b1;
      end
    end
  end

  // Reads use the pre-rename map, so sources never see their own destination.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] w_arch;
    logic [PW-1:0] w_phys;
    logic          w_zero;

    assign w_arch = rd_arch[k*AW +: AW];
    assign w_zero = (w_arch == '0);
    assign w_phys = w_zero ? '0 : r_spec_map[w_arch];
    assign rd_phys[k*PW +: PW] = w_phys;

`ifdef RENAME_RF_WB_BYPASS_EN
    logic w_byp;
    assign w_byp = w_wb_fire && (wb_phys == w_phys);
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
      w_zero ? '0 : (w_byp ? wb_data : r_regs[w_phys]);
    assign rd_rdy[k] = w_zero || w_byp || r_ready[w_phys];
`else
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_zero ? '0 : r_regs[w_phys];
    assign rd_rdy[k] = w_zero || r_ready[w_phys];
`endif
  end

  a_wb_to_allocated_tag: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_wb_fire && w_free_vec[wb_phys]));

  a_commit_frees_live_tag: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_cm_fire && w_free_vec[cm_old_phys]));

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: reset/arch-0 vectors, exhaustion,
// flush and async-reset sequences, then random traffic against a map model.
module tb_rename_reg_file;

  localparam int NA = 32;
  localparam int NP = 64;
`ifdef RENAME_RF_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        renValid;
    logic [4:0]  renArch;
    logic [4:0]  rdArch0;
    logic [4:0]  rdArch1;
    logic        wbValid;
    logic [5:0]  wbPhys;
    logic [31:0] wbData;
    logic        cmValid;
    logic [4:0]  cmArch;
    logic [5:0]  cmPhys;
    logic [5:0]  cmOld;
    logic        flush;
  } stimT;

  typedef struct {
    stimT        stim;
    logic        expReady;
    logic [5:0]  expRenPhys;
    logic [5:0]  expRenOld;
    logic [5:0]  expPhys0;
    logic [31:0] expData0;
    logic        expRdy0;
    logic [5:0]  expPhys1;
    logic [31:0] expData1;
    logic        expRdy1;
    logic [6:0]  expCount;
  } vecT;

  typedef struct {
    logic [4:0] arch;
    logic [5:0] phys;
    logic [5:0] old;
  } robT;

  logic        clk;
  logic        rst_n;
  logic        ren_valid;
  logic [4:0]  ren_arch;
  logic        ren_ready;
  logic [5:0]  ren_phys;
  logic [5:0]  ren_old_phys;
  logic [9:0]  rd_arch;
  logic [63:0] rd_data;
  logic [11:0] rd_phys;
  logic [1:0]  rd_rdy;
  logic        wb_valid;
  logic [5:0]  wb_phys;
  logic [31:0] wb_data;
  logic        cm_valid;
  logic [4:0]  cm_arch;
  logic [5:0]  cm_phys;
  logic [5:0]  cm_old_phys;
  logic        flush;
  logic [6:0]  free_count;

  int checks = 0;
  int errors = 0;

  stimT        cur;
  vecT         vecs[6];
  logic [5:0]  mSpec[NA];
  logic [5:0]  mCommit[NA];
  logic [31:0] mRegs[NP];
  bit          mReady[NP];
  bit          mFree[NP];
  robT         rob[$];

  rename_reg_file dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ren_valid    (ren_valid),
    .ren_arch     (ren_arch),
    .ren_ready    (ren_ready),
    .ren_phys     (ren_phys),
    .ren_old_phys (ren_old_phys),
    .rd_arch      (rd_arch),
    .rd_data      (rd_data),
    .rd_phys      (rd_phys),
    .rd_rdy       (rd_rdy),
    .wb_valid     (wb_valid),
    .wb_phys      (wb_phys),
    .wb_data      (wb_data),
    .cm_valid     (cm_valid),
    .cm_arch      (cm_arch),
    .cm_phys      (cm_phys),
    .cm_old_phys  (cm_old_phys),
    .flush        (flush),
    .free_count   (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stimT idle();
    stimT s;
    s = '{renValid: 1'b0, renArch: 5'd0, rdArch0: 5'd0, rdArch1: 5'd0,
          wbValid: 1'b0, wbPhys: 6'd0, wbData: 32'd0, cmValid: 1'b0,
          cmArch: 5'd0, cmPhys: 6'd0, cmOld: 6'd0, flush: 1'b0};
    return s;
  endfunction

  task automatic applyStimulus(input stimT s);
    cur         = s;
    ren_valid   = s.renValid;
    ren_arch    = s.renArch;
    rd_arch     = {s.rdArch1, s.rdArch0};
    wb_valid    = s.wbValid;
    wb_phys     = s.wbPhys;
    wb_data     = s.wbData;
    cm_valid    = s.cmValid;
    cm_arch     = s.cmArch;
    cm_phys     = s.cmPhys;
    cm_old_phys = s.cmOld;
    flush       = s.flush;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(idle());
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: maps as plain arrays, free pool as a set of flags,
  // in-flight renames as an in-order queue.
  function automatic void modelReset();
    for (int i = 0; i < NA; i++) begin
      mSpec[i]   = 6'(i);
      mCommit[i] = 6'(i);
    end
    for (int p = 0; p < NP; p++) begin
      mRegs[p]  = '0;
      mReady[p] = (p < NA);
      mFree[p]  = (p >= NA);
    end
    rob.delete();
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int p = 0; p < NP; p++) n += int'(mFree[p]);
    return n;
  endfunction

  function automatic int modelLowestFree();
    for (int p = 0; p < NP; p++) if (mFree[p]) return p;
    return 0;
  endfunction

  function automatic void modelRead(input logic [4:0] a, output logic [5:0] ph,
                                    output logic [31:0] d, output logic r);
    bit byp;
    ph  = (a == 0) ? 6'd0 : mSpec[a];
    byp = BYPASS && cur.wbValid && cur.wbPhys != 0 && cur.wbPhys == ph;
    d   = (a == 0) ? 32'd0 : (byp ? cur.wbData : mRegs[ph]);
    r   = (a == 0) || byp || mReady[ph];
  endfunction

  function automatic void modelStep();
    bit   renFire;
    int   tag;
    robT  e;
    bit   used[NP];
    renFire = cur.renValid && modelCount() > 0 && cur.renArch != 0 && !cur.flush;
    tag     = modelLowestFree();
    e       = '{arch: cur.renArch, phys: 6'(tag), old: mSpec[cur.renArch]};
    if (cur.cmValid && cur.cmArch != 0) begin
      mCommit[cur.cmArch] = cur.cmPhys;
      mFree[cur.cmOld]    = 1'b1;
    end
    if (renFire) begin
      mFree[tag]          = 1'b0;
      mReady[tag]         = 1'b0;
      mSpec[cur.renArch]  = 6'(tag);
      rob.push_back(e);
    end
    if (cur.wbValid && cur.wbPhys != 0) begin
      mRegs[cur.wbPhys]  = cur.wbData;
      mReady[cur.wbPhys] = 1'b1;
    end
    if (cur.flush) begin
      for (int p = 0; p < NP; p++) used[p] = 1'b0;
      for (int i = 0; i < NA; i++) begin
        mSpec[i]         = mCommit[i];
        used[mCommit[i]] = 1'b1;
      end
      for (int p = 0; p < NP; p++) mFree[p] = !used[p];
      rob.delete();
    end
  endfunction

  task automatic checkAgainstModel();
    logic [5:0]  ph;
    logic [31:0] d;
    logic        r;
    int          cnt;
    cnt = modelCount();
    checkOutput("rnd_ren_ready", 64'(ren_ready), 64'(cnt > 0));
    checkOutput("rnd_free_count", 64'(free_count), 64'(cnt));
    checkOutput("rnd_ren_old", 64'(ren_old_phys), 64'((cur.renArch == 0) ? 6'd0 : mSpec[cur.renArch]));
    if (cur.renArch == 0)
      checkOutput("rnd_ren_phys0", 64'(ren_phys), 64'd0);
    else if (cnt > 0)
      checkOutput("rnd_ren_phys", 64'(ren_phys), 64'(modelLowestFree()));
    modelRead(cur.rdArch0, ph, d, r);
    checkOutput("rnd_rd_phys0", 64'(rd_phys[5:0]), 64'(ph));
    checkOutput("rnd_rd_data0", 64'(rd_data[31:0]), 64'(d));
    checkOutput("rnd_rd_rdy0", 64'(rd_rdy[0]), 64'(r));
    modelRead(cur.rdArch1, ph, d, r);
    checkOutput("rnd_rd_phys1", 64'(rd_phys[11:6]), 64'(ph));
    checkOutput("rnd_rd_data1", 64'(rd_data[63:32]), 64'(d));
    checkOutput("rnd_rd_rdy1", 64'(rd_rdy[1]), 64'(r));
  endtask

  initial begin
    stimT s;
    robT  e;
    logic [5:0] p;

    rst_n = 1'b1;
    applyStimulus(idle());
    #1;

    // Reset read, rename arch 3, write-back to its new tag, arch-0 no-ops.
    s = idle(); s.rdArch0 = 5'd5;
    vecs[0] = '{s, 1'b1, 6'd0, 6'd0, 6'd5, 32'd0, 1'b1, 6'd0, 32'd0, 1'b1, 7'd32};
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd3; s.rdArch0 = 5'd3; s.rdArch1 = 5'd5;
    vecs[1] = '{s, 1'b1, 6'd32, 6'd3, 6'd3, 32'd0, 1'b1, 6'd5, 32'd0, 1'b1, 7'd32};
    s = idle(); s.renArch = 5'd3; s.rdArch0 = 5'd3; s.rdArch1 = 5'd3;
    s.wbValid = 1'b1; s.wbPhys = 6'd32; s.wbData = 32'hDEAD_BEEF;
    vecs[2] = '{s, 1'b1, 6'd33, 6'd32, 6'd32, BYPASS ? 32'hDEAD_BEEF : 32'd0, BYPASS,
                6'd32, BYPASS ? 32'hDEAD_BEEF : 32'd0, BYPASS, 7'd31};
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd0; s.rdArch0 = 5'd3;
    vecs[3] = '{s, 1'b1, 6'd0, 6'd0, 6'd32, 32'hDEAD_BEEF, 1'b1, 6'd0, 32'd0, 1'b1, 7'd31};
    s = idle(); s.renArch = 5'd7; s.rdArch0 = 5'd3; s.rdArch1 = 5'd7;
    s.wbValid = 1'b1; s.wbPhys = 6'd0; s.wbData = 32'h1234;
    vecs[4] = '{s, 1'b1, 6'd33, 6'd7, 6'd32, 32'hDEAD_BEEF, 1'b1, 6'd7, 32'd0, 1'b1, 7'd31};
    s = idle(); s.rdArch1 = 5'd3;
    vecs[5] = '{s, 1'b1, 6'd0, 6'd0, 6'd0, 32'd0, 1'b1, 6'd32, 32'hDEAD_BEEF, 1'b1, 7'd31};

    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d_ren_ready", i), 64'(ren_ready), 64'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d_ren_phys", i), 64'(ren_phys), 64'(vecs[i].expRenPhys));
      checkOutput($sformatf("vec%0d_ren_old", i), 64'(ren_old_phys), 64'(vecs[i].expRenOld));
      checkOutput($sformatf("vec%0d_rd_phys0", i), 64'(rd_phys[5:0]), 64'(vecs[i].expPhys0));
      checkOutput($sformatf("vec%0d_rd_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].expData0));
      checkOutput($sformatf("vec%0d_rd_rdy0", i), 64'(rd_rdy[0]), 64'(vecs[i].expRdy0));
      checkOutput($sformatf("vec%0d_rd_phys1", i), 64'(rd_phys[11:6]), 64'(vecs[i].expPhys1));
      checkOutput($sformatf("vec%0d_rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].expData1));
      checkOutput($sformatf("vec%0d_rd_rdy1", i), 64'(rd_rdy[1]), 64'(vecs[i].expRdy1));
      checkOutput($sformatf("vec%0d_free_count", i), 64'(free_count), 64'(vecs[i].expCount));
      tick();
    end

    // Exhaust the free list with renames of arch 1, then free tag 40.
    doReset();
    for (int i = 0; i < 32; i++) begin
      s = idle(); s.renValid = 1'b1; s.renArch = 5'd1; s.rdArch0 = 5'd1;
      applyStimulus(s);
      checkOutput("exh_ren_phys", 64'(ren_phys), 64'(32 + i));
      checkOutput("exh_ren_old", 64'(ren_old_phys), 64'((i == 0) ? 1 : 31 + i));
      tick();
    end
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd1; s.rdArch0 = 5'd1;
    applyStimulus(s);
    checkOutput("exh_ren_ready", 64'(ren_ready), 64'd0);
    checkOutput("exh_free_count", 64'(free_count), 64'd0);
    tick();
    s = idle(); s.rdArch0 = 5'd1; s.cmValid = 1'b1; s.cmArch = 5'd1;
    s.cmPhys = 6'd32; s.cmOld = 6'd40;
    applyStimulus(s);
    checkOutput("exh_map_after_33rd", 64'(rd_phys[5:0]), 64'd63);
    checkOutput("exh_count_after_33rd", 64'(free_count), 64'd0);
    checkOutput("exh_ready_commit_cycle", 64'(ren_ready), 64'd0);
    tick();
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd1; s.rdArch0 = 5'd1;
    applyStimulus(s);
    checkOutput("exh_ready_after_free", 64'(ren_ready), 64'd1);
    checkOutput("exh_count_after_free", 64'(free_count), 64'd1);
    checkOutput("exh_ren_phys_40", 64'(ren_phys), 64'd40);
    tick();
    s = idle(); s.rdArch0 = 5'd1;
    applyStimulus(s);
    checkOutput("exh_map_40", 64'(rd_phys[5:0]), 64'd40);
    checkOutput("exh_count_zero_again", 64'(free_count), 64'd0);
    tick();

    // Flush coinciding with a commit; a speculative rename is discarded.
    doReset();
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd2; applyStimulus(s); tick();
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd4; applyStimulus(s); tick();
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd5;
    s.cmValid = 1'b1; s.cmArch = 5'd2; s.cmPhys = 6'd32; s.cmOld = 6'd2;
    applyStimulus(s);
    checkOutput("fl_spec_rename_tag", 64'(ren_phys), 64'd34);
    tick();
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd6; s.flush = 1'b1;
    s.cmValid = 1'b1; s.cmArch = 5'd4; s.cmPhys = 6'd33; s.cmOld = 6'd4;
    applyStimulus(s);
    checkOutput("fl_count_before", 64'(free_count), 64'd30);
    tick();
    s = idle(); s.renArch = 5'd7; s.rdArch0 = 5'd2; s.rdArch1 = 5'd4;
    applyStimulus(s);
    checkOutput("fl_map2", 64'(rd_phys[5:0]), 64'd32);
    checkOutput("fl_map4", 64'(rd_phys[11:6]), 64'd33);
    checkOutput("fl_count", 64'(free_count), 64'd32);
    checkOutput("fl_lowest_free", 64'(ren_phys), 64'd2);
    s.rdArch0 = 5'd5; s.rdArch1 = 5'd6;
    applyStimulus(s);
    checkOutput("fl_map5_restored", 64'(rd_phys[5:0]), 64'd5);
    checkOutput("fl_map6_ignored", 64'(rd_phys[11:6]), 64'd6);
    tick();

    // Asynchronous reset in the middle of a rename burst.
    doReset();
    for (int i = 1; i <= 5; i++) begin
      s = idle(); s.renValid = 1'b1; s.renArch = 5'(i); applyStimulus(s); tick();
    end
    s = idle(); s.renValid = 1'b1; s.renArch = 5'd3; s.rdArch0 = 5'd3; s.rdArch1 = 5'd1;
    applyStimulus(s);
    checkOutput("ar_pre_map3", 64'(rd_phys[5:0]), 64'd34);
    rst_n = 1'b0;
    #1;
    checkOutput("ar_count", 64'(free_count), 64'd32);
    checkOutput("ar_ready", 64'(ren_ready), 64'd1);
    checkOutput("ar_map3", 64'(rd_phys[5:0]), 64'd3);
    checkOutput("ar_map1", 64'(rd_phys[11:6]), 64'd1);
    checkOutput("ar_ren_phys", 64'(ren_phys), 64'd32);
    checkOutput("ar_ren_old", 64'(ren_old_phys), 64'd3);
    applyStimulus(idle());
    tick();
    rst_n = 1'b1;

    // Random legal traffic: in-order commits from the in-flight queue,
    // write-backs only to allocated tags, occasional flushes.
    doReset();
    modelReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s = idle();
      s.flush = ($urandom_range(0, 39) == 0);
      if (rob.size() > 0 && $urandom_range(0, 2) == 0) begin
        e = rob.pop_front();
        s.cmValid = 1'b1; s.cmArch = e.arch; s.cmPhys = e.phys; s.cmOld = e.old;
      end
      s.renValid = ($urandom_range(0, 9) < 7);
      s.renArch  = 5'($urandom_range(0, 31));
      s.rdArch0  = 5'($urandom_range(0, 31));
      s.rdArch1  = 5'($urandom_range(0, 31));
      p = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 6 && !mFree[p]) begin
        s.wbValid = 1'b1; s.wbPhys = p; s.wbData = $urandom;
      end
      applyStimulus(s);
      checkAgainstModel();
      modelStep();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
